result_ascii_tx: RTL

RESULT_ASCII_TX -- requirements
Module: result_ascii_tx

---
 rtl/result_ascii_tx_pkg.sv | 20 ++
 rtl/result_ascii_tx_if.sv | 25 ++
 rtl/bcd_dd_step.sv | 25 ++
 rtl/result_ascii_tx.sv | 133 +++++++++++++
 4 files changed

// File: rtl/result_ascii_tx_pkg.sv
// Shared types and constants for the binary-to-ASCII decimal transmitter.
// Holds the FSM state enum, the ASCII codes used on the output and the digit-count helper.
package result_ascii_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        SEND,
        FINISH
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // ceil(width * log10(2)) using fixed-point log10(2) ~= 0.30103
    function automatic int calc_digits(input int width);
        return int'((longint'(width) * 64'sd30103 + 64'sd99999) / 64'sd100000);
    endfunction

endpackage

// File: rtl/result_ascii_tx_if.sv
// Request/byte-stream bundle between a result producer, the ASCII transmitter and a byte sink.
// A byte moves when out_valid and out_ready are both high on a rising clk; while out_valid is high
// and out_ready is low, out_data/out_valid/out_last hold, and out_valid never depends on out_ready.
interface result_ascii_tx_if #(
    parameter int WIDTH = 15
);
    logic             start;
    logic [WIDTH-1:0] value;
    logic             busy;
    logic             done;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        input  start, value, out_ready,
        output busy, done, out_data, out_valid, out_last
    );

    modport slave (
        output start, value, out_ready,
        input  busy, done, out_data, out_valid, out_last
    );
endinterface

// File: rtl/bcd_dd_step.sv
// One combinational double-dabble iteration: add 3 to every BCD nibble >= 5,
// then shift the concatenation {bcd, bin} left by one bit.
module bcd_dd_step #(
    parameter int WIDTH  = 15,
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] bcd_in,
    input  logic [WIDTH-1:0]    bin_in,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [WIDTH-1:0]    bin_out
);
    logic [4*DIGITS-1:0] adj;

    always_comb begin
        adj = bcd_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_in[4*i +: 4] + 4'd3;
            end
        end
    end

    assign {bcd_out, bin_out} = {adj, bin_in} << 1;

endmodule

// File: rtl/result_ascii_tx.sv
// Converts an unsigned binary result to decimal (double-dabble, one bit per cycle) and
// streams it as ASCII digits, most significant first without leading zeros, ending in LF.
module result_ascii_tx
    import result_ascii_tx_pkg::*;
#(
    parameter int WIDTH  = 15,
    parameter int DIGITS = calc_digits(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    result_ascii_tx_if.master  bus,
    output state_t             state_dbg
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   bin_q, bin_n, step_bin;
    logic [BCD_W-1:0]   bcd_q, bcd_n, step_bcd;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [PTR_W-1:0]   ptr_q, ptr_n, msd_ptr;
    logic               lf_q, lf_n;
    logic [3:0]         cur_digit;

    bcd_dd_step #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_step (
        .bcd_in  (bcd_q),
        .bin_in  (bin_q),
        .bcd_out (step_bcd),
        .bin_out (step_bin)
    );

    // Highest non-zero nibble of the final conversion result; stays 0 for value 0.
    always_comb begin
        msd_ptr = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (step_bcd[4*i +: 4] != 4'd0) begin
                msd_ptr = PTR_W'(i);
            end
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                cur_digit = bcd_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_n = state_q;
        bin_n   = bin_q;
        bcd_n   = bcd_q;
        cnt_n   = cnt_q;
        ptr_n   = ptr_q;
        lf_n    = lf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bin_n   = bus.value;
                    bcd_n   = '0;
                    cnt_n   = '0;
                    state_n = CONVERT;
                end
            end
            CONVERT: begin
                bin_n = step_bin;
                bcd_n = step_bcd;
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    ptr_n   = msd_ptr;
                    lf_n    = 1'b0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (lf_q) begin
                        state_n = FINISH;
                    end else if (ptr_q == '0) begin
                        lf_n = 1'b1;
                    end else begin
                        ptr_n = ptr_q - 1'b1;
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            lf_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            bin_q   <= bin_n;
            bcd_q   <= bcd_n;
            cnt_q   <= cnt_n;
            ptr_q   <= ptr_n;
            lf_q    <= lf_n;
        end
    end

    // Outputs decode registered state only, so out_valid has no path from out_ready.
    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.out_valid = (state_q == SEND);
        bus.out_last  = (state_q == SEND) && lf_q;
        bus.done      = (state_q == FINISH);
        bus.out_data  = 8'h00;
        if (state_q == SEND) begin
            bus.out_data = lf_q ? ASCII_LF : (ASCII_ZERO + {4'd0, cur_digit});
        end
    end

    assign state_dbg = state_q;

endmodule
